// File: rtl/div_8x4_seq.sv
// rtl/div_8x4_seq.sv - 8-by-4 unsigned restoring divider, one quotient bit per clock
module div_8x4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] N,
    input  logic [3:0] D,
    output logic       busy,
    output logic       done,
    output logic [7:0] Q,
    output logic [3:0] R,
    output logic       dz
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t     state_q;
    logic [7:0] n_q;        // dividend, shifted left so bit 7 is always the next bit
    logic [3:0] d_q;        // divisor latched at the start edge
    logic [4:0] rem_q;      // partial remainder, always < d_q between steps
    logic [7:0] quo_q;      // quotient bits collected so far, MSB first
    logic [2:0] cnt_q;      // step number within the current division
    logic       busy_q;
    logic       done_q;
    logic       dz_q;
    logic [7:0] q_q;
    logic [3:0] r_q;

    logic [5:0] shifted_d;
    logic       take_d;
    logic [4:0] rem_d;
    logic [7:0] quo_d;

    // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
    always_comb begin
        shifted_d = {rem_q, n_q[7]};
        take_d    = (shifted_d >= {2'b00, d_q});
        rem_d     = take_d ? 5'(shifted_d - {2'b00, d_q}) : shifted_d[4:0];
        quo_d     = {quo_q[6:0], take_d};
    end

    // Control FSM and datapath registers; reset wins over start and over any step
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= 8'h00;
            d_q     <= 4'h0;
            rem_q   <= 5'h00;
            quo_q   <= 8'h00;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= 8'h00;
            r_q     <= 4'h0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (D == 4'h0) begin
                            // Divide by zero resolves immediately without entering CALC
                            q_q    <= 8'hFF;
                            r_q    <= 4'h0;
                            dz_q   <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            n_q     <= N;
                            d_q     <= D;
                            rem_q   <= 5'h00;
                            quo_q   <= 8'h00;
                            cnt_q   <= 3'd0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    n_q   <= {n_q[6:0], 1'b0};
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        q_q     <= quo_d;
                        r_q     <= rem_d[3:0];
                        dz_q    <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_div_8x4_seq.sv
// tb/tb_div_8x4_seq.sv - self-checking bench for div_8x4_seq against a behavioural model
module tb_div_8x4_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] n_in;
    logic [3:0] d_in;
    logic       busy;
    logic       done;
    logic [7:0] Q;
    logic [3:0] R;
    logic       dz;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    // Behavioural model: expected outputs after the most recent rising edge
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_q    = 8'h00;
    logic [3:0] m_r    = 4'h0;
    logic       m_dz   = 1'b0;
    int         m_remain = 0;
    int         pend_n   = 0;
    int         pend_d   = 1;

    div_8x4_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .N     (n_in),
        .D     (d_in),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs presented to the DUT
    task model_update();
        if (rst) begin
            m_remain = 0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_q      = 8'h00;
            m_r      = 4'h0;
            m_dz     = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_q    = 8'(pend_n / pend_d);
                    m_r    = 4'(pend_n % pend_d);
                    m_dz   = 1'b0;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (start) begin
                if (d_in == 4'h0) begin
                    m_q    = 8'hFF;
                    m_r    = 4'h0;
                    m_dz   = 1'b1;
                    m_done = 1'b1;
                end else begin
                    pend_n   = int'(n_in);
                    pend_d   = int'(d_in);
                    m_remain = 8;
                    m_busy   = 1'b1;
                end
            end
        end
    endtask

    // Present inputs at a falling edge, clock once, return at the next falling edge
    task automatic cycle(input logic r, input logic s, input logic [7:0] n, input logic [3:0] d);
        rst   = r;
        start = s;
        n_in  = n;
        d_in  = d;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Single compare process: every output against the model on every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("Q",    32'(Q),    32'(m_q));
            check("R",    32'(R),    32'(m_r));
            check("dz",   32'(dz),   32'(m_dz));
        end
    end

    // Start one division and run it to completion with noisy inputs while busy
    task automatic do_div(input logic [7:0] n, input logic [3:0] d, output int busy_cnt);
        busy_cnt = 0;
        cycle(1'b0, 1'b1, n, d);
        if (busy) busy_cnt++;
        if (d != 4'h0) begin
            for (int i = 0; i < 8; i++) begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom));
                if (busy) busy_cnt++;
            end
        end
    endtask

    int bc;
    int pulses;
    int last_pulse;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        n_in  = 8'h00;
        d_in  = 4'h0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 8'h00, 4'h0);
        cycle(1'b1, 1'b1, 8'h12, 4'h3);
        chk_en = 1'b1;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q",    32'(Q),    32'd0);
        check("rst_r",    32'(R),    32'd0);
        check("rst_dz",   32'(dz),   32'd0);

        // 200 / 13
        do_div(8'd200, 4'd13, bc);
        check("d200_busycnt", 32'(bc), 32'd8);
        check("d200_done", 32'(done), 32'd1);
        check("d200_q", 32'(Q), 32'd15);
        check("d200_r", 32'(R), 32'd5);
        check("d200_dz", 32'(dz), 32'd0);

        // 255 / 1 then back-to-back 7 / 9
        do_div(8'd255, 4'd1, bc);
        check("d255_q", 32'(Q), 32'd255);
        check("d255_r", 32'(R), 32'd0);
        do_div(8'd7, 4'd9, bc);
        check("d7_done", 32'(done), 32'd1);
        check("d7_q", 32'(Q), 32'd0);
        check("d7_r", 32'(R), 32'd7);

        // Divide by zero: one-clock latency, busy never rises
        cycle(1'b0, 1'b1, 8'h5A, 4'h0);
        check("dz_done", 32'(done), 32'd1);
        check("dz_busy", 32'(busy), 32'd0);
        check("dz_q", 32'(Q), 32'hFF);
        check("dz_r", 32'(R), 32'd0);
        check("dz_dz", 32'(dz), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 4'h3);
        check("dz_done_clr", 32'(done), 32'd0);
        check("dz_hold", 32'(dz), 32'd1);

        // Reset at E4 aborts the division
        cycle(1'b0, 1'b1, 8'd200, 4'd13);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'd200, 4'd13);
        cycle(1'b1, 1'b0, 8'd200, 4'd13);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_q", 32'(Q), 32'd0);
        check("abort_r", 32'(R), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 8'd200, 4'd13);
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        // start held high: a pulse every 9 cycles
        pulses = 0;
        last_pulse = 0;
        for (int c = 1; c <= 36; c++) begin
            cycle(1'b0, 1'b1, 8'd100, 4'd7);
            if (done) begin
                pulses++;
                check("hold_q", 32'(Q), 32'd14);
                check("hold_r", 32'(R), 32'd2);
                check("hold_period", 32'(c - last_pulse), 32'd9);
                last_pulse = c;
            end
        end
        check("hold_pulses", 32'(pulses), 32'd4);

        // Exhaustive sweep against the arithmetic rule
        for (int n = 0; n < 256; n++) begin
            for (int d = 0; d < 16; d++) begin
                do_div(8'(n), 4'(d), bc);
                if (done !== 1'b1) begin
                    check("sweep_done", 32'(done), 32'd1);
                end else if (d == 0) begin
                    if (dz !== 1'b1 || Q !== 8'hFF || R !== 4'h0)
                        check("sweep_dz", {23'd0, dz, Q}, {23'd0, 1'b1, 8'hFF});
                    else
                        n_checks++;
                end else begin
                    check("sweep_rule", 32'(int'(Q) * d + int'(R)), 32'(n));
                    check("sweep_r_lt_d", 32'(int'(R) < d), 32'd1);
                end
            end
        end

        // Free-running random traffic including occasional reset
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                  8'($urandom), 4'($urandom));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_8x4_seq.md
DIV_8X4_SEQ -- requirements
Module: div_8x4_seq

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a division; sampled only when busy=0.
REQ-005 N  input  8  dividend, unsigned; same width as the 4x4 multiplier product.
REQ-006 D  input  4  divisor, unsigned.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse when Q, R and dz are valid.
REQ-009 Q  output  8  quotient, unsigned.
REQ-010 R  output  4  remainder, unsigned, always less than D when dz=0.
REQ-011 dz  output  1  divide-by-zero flag; valid with done, held with Q and R.

Function
REQ-012 Method: restoring shift-subtract division, one quotient bit per clock, MSB first.
REQ-013 FSM states: IDLE and CALC; no other states are reachable.
REQ-014 IDLE with start=1 and D!=0, on edge E0:
- latch N and D internally;
- clear the partial remainder (5 bits) and the iteration counter (3 bits);
- set busy=1;
- go to CALC.
REQ-015 CALC, each edge E1..E8:
- shift remainder left, bringing in the next dividend bit (N[7] first);
- trial-subtract D;
- if the result is non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
REQ-016 At E8:
- write the final quotient to Q and the final remainder to R;
- set dz=0, done=1 and busy=0;
- return to IDLE.
- Latency is exactly 8 clocks from the start edge to the done-visible edge.
REQ-017 IDLE with start=1 and D=0, on edge E0:
- Q=8'hFF, R=4'h0, dz=1, done=1;
- busy stays 0 and the state stays IDLE (latency 1 clock).
REQ-018 done is high for exactly one cycle and is cleared on the next edge.
REQ-019 Q, R and dz hold their values until the next done or reset.
REQ-020 start while busy=1 is ignored: no queueing and no effect on the computation in flight.
REQ-021 N and D may change freely while busy=1; the result depends only on the values latched at E0.
REQ-022 Back-to-back operation:
- start asserted in the cycle where done=1 is accepted (busy=0 in that cycle);
- that same edge clears done and loads the new operands.
REQ-023 Arithmetic rule: when dz=0, N = Q*D + R and R < D for every N in 0..255 and D in 1..15.
REQ-024 No combinational path from any input to any output; all outputs are registered.

Reset
REQ-025 When rst=1 at an edge:
- state=IDLE;
- busy=0, done=0, dz=0, Q=8'h00, R=4'h0;
- internal remainder and counter cleared.
REQ-026 rst has priority over start and over any CALC step.
REQ-027 Reset mid-operation aborts the division: no done pulse follows, and Q and R read zero.

Verification
REQ-028 N=200, D=13, start pulse -> busy for 8 cycles, then done=1 with Q=8'd15, R=4'd5, dz=0.
REQ-029 N=255, D=1 -> Q=8'd255, R=0 at 8 cycles; then N=7, D=9 -> Q=0, R=7.
REQ-030 N=0x5A, D=0 -> done on the next edge, busy never high, Q=8'hFF, R=0, dz=1.
REQ-031 Start accepted, then rst=1 at E4 -> from E4 onward busy=0, Q=0, R=0, done never pulses.
REQ-032 start held high continuously with N=100, D=7 -> done pulses every 9 cycles, each with Q=14, R=2, and no pulse is lost.
REQ-033 Exhaustive sweep: N=0..255, D=0..15 checked against the arithmetic rule and the dz behaviour; busy toggling N and D during CALC changes no result.
